// File: rtl/sync_fifo_thr.sv
// sync_fifo_thr
//   Parametrised single-clock FIFO with show-ahead read data, a fill level
//   sized 0..DEPTH, runtime-programmable almost-full/almost-empty thresholds
//   and sticky overflow/underflow flags that record illegal accesses.
//
// Parameters
//   WIDTH    data width in bits
//   L2D      log2 of depth (DEPTH = 1 << L2D)
//   REGFLAGS 1: empty/full/almost_* come from flops, 0: decoded from level
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   enable               clock enable, low holds every bit of state
//   clear                synchronous clear, wins over read/write
//   write, wdata         push request and data
//   read, rdata          pop request and head-of-FIFO data (show-ahead)
//   empty, full, level   occupancy status
//   af_thresh, ae_thresh almost-full / almost-empty thresholds
//   almost_full          level >= af_thresh
//   almost_empty         level <= ae_thresh
//   overflow, underflow  sticky error flags, cleared by err_clr or clear
//   err_clr              clears the error flags (and peak)
//   peak                 high-water mark
//
// Build option
//   SYNC_FIFO_PEAK_EN    when defined, peak is a real high-water register;
//                        otherwise peak is tied to zero.
module sync_fifo_thr #(
  parameter int WIDTH    = 8,
  parameter int L2D      = 4,
  parameter int REGFLAGS = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             write,
  input  logic [WIDTH-1:0] wdata,
  input  logic             read,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [L2D:0]     level,
  input  logic [L2D:0]     af_thresh,
  input  logic [L2D:0]     ae_thresh,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr,
  output logic [L2D:0]     peak
);

  localparam int           DEPTH     = 1 << L2D;
  localparam logic [L2D:0] DEPTH_LVL = (L2D+1)'(DEPTH);
  localparam logic [L2D:0] ONE_LVL   = (L2D+1)'(1);
  localparam logic [L2D-1:0] ONE_PTR = L2D'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [L2D-1:0]   wr_pntr;
  logic [L2D-1:0]   rd_pntr;
  logic [L2D:0]     next_level;
  logic             lvl_empty;
  logic             lvl_full;
  logic             l_wr;
  logic             l_rd;

  // Acceptance is judged on the level register itself, so both flag styles
  // gate the pointers identically.
  assign lvl_empty = (level == '0);
  assign lvl_full  = (level == DEPTH_LVL);
  assign l_wr      = write & ~lvl_full;
  assign l_rd      = read  & ~lvl_empty;

  always_comb begin
    next_level = level;
    if (l_wr && !l_rd)
      next_level = level + ONE_LVL;
    else if (l_rd && !l_wr)
      next_level = level - ONE_LVL;
  end

  // Pointers, level and the sticky error flags. A fresh error in the same
  // cycle as err_clr leaves the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_pntr   <= '0;
      rd_pntr   <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (enable) begin
      if (clear) begin
        wr_pntr   <= '0;
        rd_pntr   <= '0;
        level     <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (l_wr) wr_pntr <= wr_pntr + ONE_PTR;
        if (l_rd) rd_pntr <= rd_pntr + ONE_PTR;
        level     <= next_level;
        overflow  <= (overflow  & ~err_clr) | (write & lvl_full);
        underflow <= (underflow & ~err_clr) | (read  & lvl_empty);
      end
    end
  end

  // Storage is never reset; only accepted writes touch it.
  always_ff @(posedge clk) begin
    if (enable && !clear && l_wr)
      mem[wr_pntr] <= wdata;
  end

  assign rdata = mem[rd_pntr];

  generate
    if (REGFLAGS != 0) begin : g_regflags
      logic empty_q, full_q, af_q, ae_q;

      // Flags are loaded from the level that is about to be written, so they
      // change on the same edge as level; thresholds are sampled here too.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          empty_q <= 1'b1;
          full_q  <= 1'b0;
          af_q    <= 1'b0;
          ae_q    <= 1'b1;
        end else if (enable) begin
          if (clear) begin
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
          end else begin
            empty_q <= (next_level == '0);
            full_q  <= (next_level == DEPTH_LVL);
            af_q    <= (next_level >= af_thresh);
            ae_q    <= (next_level <= ae_thresh);
          end
        end
      end

      assign empty        = empty_q;
      assign full         = full_q;
      assign almost_full  = af_q;
      assign almost_empty = ae_q;
    end else begin : g_combflags
      assign empty        = lvl_empty;
      assign full         = lvl_full;
      assign almost_full  = (level >= af_thresh);
      assign almost_empty = (level <= ae_thresh);
    end
  endgenerate

`ifdef SYNC_FIFO_PEAK_EN
  logic [L2D:0] peak_q;

  // High-water mark; err_clr takes priority over a same-cycle new maximum.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak_q <= '0;
    end else if (enable) begin
      if (clear || err_clr)
        peak_q <= '0;
      else if (next_level > peak_q)
        peak_q <= next_level;
    end
  end

  assign peak = peak_q;
`else
  assign peak = '0;
`endif

endmodule

// File: tb/tb_sync_fifo_thr.sv
// tb_sync_fifo_thr
//   Directed scenarios followed by a randomized run, all checked against a
//   queue-based reference model of the FIFO kept inside this bench.
module tb_sync_fifo_thr;

  localparam int WIDTH = 8;
  localparam int L2D   = 4;
  localparam int DEPTH = 16;
`ifdef SYNC_FIFO_PEAK_EN
  localparam bit PEAK_EN = 1'b1;
`else
  localparam bit PEAK_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic             enable;
  logic             clear;
  logic             write;
  logic [WIDTH-1:0] wdata;
  logic             read;
  logic [WIDTH-1:0] rdata;
  logic             empty;
  logic             full;
  logic [L2D:0]     level;
  logic [L2D:0]     af_thresh;
  logic [L2D:0]     ae_thresh;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;
  logic             err_clr;
  logic [L2D:0]     peak;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int q[$];
  bit m_ovf, m_unf, m_af, m_ae;
  int m_peak;

  sync_fifo_thr #(.WIDTH(WIDTH), .L2D(L2D), .REGFLAGS(1)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
    .write(write), .wdata(wdata), .read(read), .rdata(rdata),
    .empty(empty), .full(full), .level(level),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow),
    .err_clr(err_clr), .peak(peak)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    check("level", 32'(level), 32'(q.size()));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("almost_full", 32'(almost_full), 32'(m_af));
    check("almost_empty", 32'(almost_empty), 32'(m_ae));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_unf));
    check("peak", 32'(peak), PEAK_EN ? 32'(m_peak) : 32'd0);
    if (q.size() > 0)
      check("rdata", 32'(rdata), 32'(q[0]));
  endtask

  // Drive one clock's worth of inputs, advance the model, check after the edge.
  task automatic applyStimulus(input bit en, input bit clr, input bit wr,
                               input logic [7:0] wd, input bit rd, input bit ec);
    bit was_full, was_empty;
    @(negedge clk);
    enable = en; clear = clr; write = wr; wdata = wd; read = rd; err_clr = ec;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (en) begin
      if (clr) begin
        q.delete();
        m_ovf = 0; m_unf = 0; m_peak = 0; m_af = 0; m_ae = 1;
      end else begin
        if (rd && !was_empty) void'(q.pop_front());
        if (wr && !was_full) q.push_back(int'(wd));
        m_ovf = (m_ovf && !ec) || (wr && was_full);
        m_unf = (m_unf && !ec) || (rd && was_empty);
        if (ec) m_peak = 0;
        else if (q.size() > m_peak) m_peak = q.size();
        m_af = (q.size() >= int'(af_thresh));
        m_ae = (q.size() <= int'(ae_thresh));
      end
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic push(input logic [7:0] d);
    applyStimulus(1, 0, 1, d, 0, 0);
  endtask

  task automatic pop();
    applyStimulus(1, 0, 0, 8'h00, 1, 0);
  endtask

  initial begin
    reset_n = 0; enable = 0; clear = 0; write = 0; wdata = 0; read = 0;
    err_clr = 0; af_thresh = 5'd12; ae_thresh = 5'd3;
    m_ovf = 0; m_unf = 0; m_af = 0; m_ae = 1; m_peak = 0;
    #23;
    checkOutput();
    @(negedge clk);
    reset_n = 1;
    #1;
    checkOutput();

    // Fill with 0x00..0x0F then drain in order
    for (int i = 0; i < 16; i++) push(8'(i));
    check("fill_full", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) pop();
    check("drain_empty", 32'(empty), 32'd1);

    // Overflow from full, 0xAA must never appear
    for (int i = 0; i < 16; i++) push(8'(i + 32));
    push(8'hAA);
    check("ovf_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check("no_aa", 32'(rdata == 8'hAA), 32'd0);
      pop();
    end
    pop();
    check("unf_set", 32'(underflow), 32'd1);
    applyStimulus(1, 0, 0, 8'h00, 0, 1);
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Level 5 held through pointer wrap with simultaneous read+write
    for (int i = 0; i < 5; i++) push(8'(i + 100));
    for (int i = 0; i < 40; i++) applyStimulus(1, 0, 1, 8'(i + 110), 1, 0);
    check("rw_level5", 32'(level), 32'd5);

    // Threshold behaviour
    applyStimulus(1, 1, 0, 8'h00, 0, 0);
    af_thresh = 5'd12; ae_thresh = 5'd3;
    for (int i = 0; i < 11; i++) push(8'(i + 60));
    check("af_low_at_11", 32'(almost_full), 32'd0);
    push(8'h77);
    check("af_high_at_12", 32'(almost_full), 32'd1);
    for (int i = 0; i < 9; i++) pop();
    check("ae_at_3", 32'(almost_empty), 32'd1);
    push(8'h78);
    check("ae_low_at_4", 32'(almost_empty), 32'd0);
    ae_thresh = 5'd5;
    #1;
    check("ae_not_yet", 32'(almost_empty), 32'd0);
    applyStimulus(1, 0, 0, 8'h00, 0, 0);
    check("ae_after_thresh", 32'(almost_empty), 32'd1);

    // Clear together with a write at level 9, then enable held low
    for (int i = 0; i < 5; i++) push(8'(i + 80));
    check("level9", 32'(level), 32'd9);
    applyStimulus(1, 1, 1, 8'h55, 0, 0);
    check("clear_empty", 32'(empty), 32'd1);
    for (int i = 0; i < 3; i++) push(8'(i + 90));
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 8'hEE, 1, 1);
    check("hold_level", 32'(level), 32'd3);

    // High-water mark
    applyStimulus(1, 1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 13; i++) push(8'(i + 140));
    for (int i = 0; i < 11; i++) pop();
    check("peak13", 32'(peak), PEAK_EN ? 32'd13 : 32'd0);
    applyStimulus(1, 0, 0, 8'h00, 0, 1);
    check("peak_cleared", 32'(peak), 32'd0);

    // Randomized run
    for (int i = 0; i < 800; i++) begin
      bit en, clr, wr, rd, ec;
      int bias;
      bias = (i / 100) % 2 == 0 ? 7 : 3;
      if ($urandom_range(0, 29) == 0) af_thresh = 5'($urandom_range(0, 17));
      if ($urandom_range(0, 29) == 0) ae_thresh = 5'($urandom_range(0, 17));
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 79) == 0);
      wr  = ($urandom_range(0, 9) < bias);
      rd  = ($urandom_range(0, 9) >= bias);
      if ($urandom_range(0, 3) == 0) rd = 1;
      ec  = ($urandom_range(0, 24) == 0);
      applyStimulus(en, clr, wr, 8'($urandom), rd, ec);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
